// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: single-outstanding dbus memory responder with fixed latency, stall and 64-bit RAM
module dbus_mem_responder #(
   parameter int          ADDR_BITS = 10,
   parameter int          LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [7:0]  req_strobe,
   input  logic [63:0] req_data,
   input  logic        stall,
   output logic        resp_addr_ok,
   output logic        resp_data_ok,
   output logic [63:0] resp_data,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]  idx_q, idx_d;
   logic                  hit_q, hit_d;
   logic [7:0]            strb_q, strb_d;
   logic [63:0]           wdata_q, wdata_d;
   logic [63:0]           mem [2**ADDR_BITS];
   logic [63:0]           off;
   logic                  unused_ok;
   assign off       = req_addr - BASE_ADDR;
   assign unused_ok = ^{req_size, off[2:0]};
   // cnt counts remaining WAIT cycles; the last unstalled one moves to RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      hit_d   = hit_q;
      strb_d  = strb_q;
      wdata_d = wdata_q;
      if (state_q == IDLE && req_valid) begin
         idx_d   = off[ADDR_BITS+2:3];
         hit_d   = req_addr >= BASE_ADDR && off[63:ADDR_BITS+3] == '0;
         strb_d  = req_strobe;
         wdata_d = req_data;
         cnt_d   = LAT_M1;
         state_d = LATENCY == 1 ? RESP : WAIT;
      end else if (state_q == WAIT && !stall) begin
         cnt_d   = cnt_q - 4'd1;
         state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         strb_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
      end
   end
   always_ff @(posedge clk) begin
      if (!reset && state_q == RESP && hit_q)
         for (int i = 0; i < 8; i++)
            if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
   end
   assign resp_data_ok = state_q == RESP;
   assign resp_addr_ok = resp_data_ok;
   assign busy         = state_q != IDLE;
   assign resp_data    = resp_data_ok && hit_q ? mem[idx_q] : '0;
endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Data-bus responder (memory side) for the core's dbus initiator: accepts one valid/addr/size/strobe/data request at a time and answers with a single-cycle data_ok pulse plus read data.
- Backed by an internal word-addressed 64-bit RAM with configurable response latency and an external stall input for backpressure.
- Sits between the core's dbus port and the simulation top. Standalone memory model for pipeline bring-up and handshake verification.

Parameters:
- ADDR_BITS, 10, log2 of RAM depth in 64-bit words (1024 words = 8 KiB).
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15.
- BASE_ADDR, 64'h8000_0000, byte address mapped to RAM word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request valid; initiator holds it until it sees data_ok
- req_addr  in  64  byte address
- req_size  in  3  access size code (informational; not used for lane selection)
- req_strobe  in  8  byte-lane write enables; 0 means read
- req_data  in  64  write data, already lane-aligned by initiator
- stall  in  1  freezes latency counter (backpressure injection)
- resp_addr_ok  out  1  request accepted; same timing as resp_data_ok
- resp_data_ok  out  1  one-cycle completion pulse
- resp_data  out  64  full aligned 64-bit word; valid only while resp_data_ok=1
- busy  out  1  high in WAIT or RESP

Behaviour:
- Reset (sync, active-high): state=IDLE, counter=0, latched request cleared; resp_addr_ok=0, resp_data_ok=0, resp_data=0, busy=0. RAM contents are not cleared.
- Reset mid-transaction aborts it: no data_ok is issued and a pending write is dropped.
- Word index = (req_addr - BASE_ADDR)[ADDR_BITS+2:3]. Low 3 address bits are ignored for indexing.
- In range: BASE_ADDR <= addr < BASE_ADDR + 8*2^ADDR_BITS. Out of range: reads return 64'h0 and writes are dropped. The handshake completes normally in both cases.
- FSM IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: if req_valid=1, latch addr/strobe/data at the clock edge, load counter = LATENCY-1, go to WAIT. If LATENCY=1, go straight to RESP.
  - WAIT: counter decrements each cycle that stall=0 and holds while stall=1. When the counter reaches 0 with stall=0, go to RESP.
  - RESP (one cycle): resp_data_ok=resp_addr_ok=1; resp_data = RAM[latched index] before the write. If latched strobe != 0, bytes with strobe[i]=1 are written at the end of this cycle; others are untouched. Next state is IDLE unconditionally.
- Latency: request sampled at edge ending cycle T; data_ok asserted in cycle T+LATENCY plus the number of stall cycles seen in WAIT.
- req_* changes while in WAIT/RESP are ignored; only values latched in IDLE are used.
- req_valid is not sampled in RESP. In IDLE it is always treated as a new request. The initiator must drop valid the cycle after data_ok, or it will issue a second access.
- Read-after-write: a read accepted after a write's RESP cycle sees the written bytes.
- stall while in IDLE or RESP has no effect.
- resp_data = 0 in every non-RESP cycle.

Test Plan:
- Reset, then read addr 64'h8000_0000 with LATENCY=2 -> data_ok exactly 2 cycles after acceptance, resp_data=64'h0 (initialised RAM). addr_ok coincides with data_ok, busy high for 2 cycles.
- Write 64'h1122_3344_5566_7788 strobe 8'hFF to 64'h8000_0008, then write 64'hAAAA_AAAA_AAAA_AAAA strobe 8'h0F, then read 64'h8000_0008 -> 64'h1122_3344_AAAA_AAAA.
- Read 64'h8000_0008 with stall held high for 3 cycles during WAIT -> data_ok at acceptance+5. Exactly one pulse. A req_addr change to 64'h8000_0010 mid-WAIT is ignored.
- Write 64'hDEAD_BEEF to out-of-range 64'h0000_1000, then read it -> both complete with one data_ok. Read returns 0, RAM[0..1023] unchanged.
- Assert reset in WAIT of a write of 64'hFFFF to 64'h8000_0000 -> no data_ok, busy=0 next cycle, subsequent read of 64'h8000_0000 returns the prior value.
- Back-to-back: valid dropped one cycle after data_ok, then two reads issued 1 cycle apart -> two data_ok pulses separated by LATENCY+1 cycles, with no lost or duplicated access.
